// File: rtl/iter_divider_ctrl.sv
// Iterative restoring divider with start/busy/done handshake.
// One quotient bit per cycle in CALC, an optional sign-fix cycle, and a
// divide-by-zero fast path that goes straight to DONE. Result ports are
// loaded only on the edge that raises done, so they hold between divides.
module iter_divider_ctrl #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem_w;
    logic [WIDTH-1:0] quo_w;
    logic [WIDTH-1:0] dvs_mag;
    logic             neg_quo;
    logic             neg_rem;
    logic             dbz_w;
    logic             accept;
    logic             last_step;
    logic             signed_act;
    logic             dvs_zero;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Two's-complement negate, wrapping (MIN stays MIN).
    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
        return '0 - v;
    endfunction

    // Unsigned magnitude of an operand; MIN maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                             input logic en);
        logic [WIDTH-1:0] u;
        u = v;
        return (en && v[WIDTH-1]) ? neg(u) : u;
    endfunction

    assign signed_act = SIGNED_EN && signed_mode;
    assign dvs_zero   = (divisor == '0);
    // Partial remainder needs one extra bit after the shift for unsigned divisors near 2^WIDTH.
    assign shifted    = {rem_w, quo_w[WIDTH-1]};
    assign trial      = shifted - {1'b0, dvs_mag};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = dvs_zero ? DONE : CALC;
            CALC:    if (last_step) state_nxt = SIGNED_EN ? FIX : DONE;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control strobes decoded from the current state.
    always_comb begin
        accept    = 1'b0;
        last_step = 1'b0;
        if (state == IDLE && start)            accept    = 1'b1;
        if (state == CALC && count == CW'(WIDTH - 1)) last_step = 1'b1;
    end

    // Working datapath: operand capture, restoring steps, sign fix.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (dvs_zero) begin
                quo_w <= '1;
                rem_w <= dividend;
            end else begin
                quo_w <= mag(dividend, signed_act);
                rem_w <= '0;
            end
            dvs_mag <= mag(divisor, signed_act);
            neg_quo <= signed_act && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem <= signed_act && dividend[WIDTH-1];
            dbz_w   <= dvs_zero;
        end else if (state == CALC) begin
            rem_w <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            quo_w <= {quo_w[WIDTH-2:0], ~trial[WIDTH]};
        end else if (state == FIX) begin
            if (neg_quo) quo_w <= neg(quo_w);
            if (neg_rem) rem_w <= neg(rem_w);
        end
    end

    // Handshake, iteration counter and result ports.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= (state == DONE);
            if (accept) begin
                busy  <= 1'b1;
                count <= '0;
            end else if (state == CALC) begin
                count <= count + CW'(1);
            end
            if (state == DONE) begin
                busy        <= 1'b0;
                quotient    <= quo_w;
                remainder   <= rem_w;
                div_by_zero <= dbz_w;
            end
        end
    end

endmodule

// File: tb/tb_iter_divider_ctrl.sv
// Bench for iter_divider_ctrl: three instances (32-bit signed-capable,
// 8-bit signed-capable, 16-bit unsigned-only) checked against a plain
// arithmetic reference model, a vector table and hand-written sequences.
module tb_iter_divider_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        st0, sm0, busy0, done0, z0;
    logic [31:0] a0, b0, q0, r0;
    logic        st1, sm1, busy1, done1, z1;
    logic [7:0]  a1, b1, q1, r1;
    logic        st2, sm2, busy2, done2, z2;
    logic [15:0] a2, b2, q2, r2;

    iter_divider_ctrl #(.WIDTH(32), .SIGNED_EN(1'b1)) u_w32 (
        .clk(clk), .rst(rst), .start(st0), .signed_mode(sm0), .dividend(a0), .divisor(b0),
        .quotient(q0), .remainder(r0), .busy(busy0), .done(done0), .div_by_zero(z0));
    iter_divider_ctrl #(.WIDTH(8), .SIGNED_EN(1'b1)) u_w8 (
        .clk(clk), .rst(rst), .start(st1), .signed_mode(sm1), .dividend(a1), .divisor(b1),
        .quotient(q1), .remainder(r1), .busy(busy1), .done(done1), .div_by_zero(z1));
    iter_divider_ctrl #(.WIDTH(16), .SIGNED_EN(1'b0)) u_w16 (
        .clk(clk), .rst(rst), .start(st2), .signed_mode(sm2), .dividend(a2), .divisor(b2),
        .quotient(q2), .remainder(r2), .busy(busy2), .done(done2), .div_by_zero(z2));

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int          u;
        logic [63:0] a, b;
        bit          sm;
        logic [63:0] q, r;
        bit          z;
        int          lat;
    } vec_t;

    function automatic int wof(input int u);
        return (u == 0) ? 32 : (u == 1) ? 8 : 16;
    endfunction

    function automatic bit sen_of(input int u);
        return (u == 2) ? 1'b0 : 1'b1;
    endfunction

    // Reference: plain integer division with truncation toward zero.
    task automatic model(input int w, input bit sen, input logic [63:0] ai, input logic [63:0] bi,
                         input bit sm, output logic [63:0] q, output logic [63:0] r,
                         output bit z, output int lat);
        logic [63:0] m, a, b;
        longint sa, sb;
        m = (64'd1 << w) - 64'd1;
        a = ai & m;
        b = bi & m;
        if (b == 0) begin
            q = m; r = a; z = 1'b1; lat = 1;
        end else begin
            z   = 1'b0;
            lat = sen ? w + 2 : w + 1;
            if (sen && sm) begin
                sa = longint'(a);
                sb = longint'(b);
                if (a[w-1]) sa = sa - (longint'(1) <<< w);
                if (b[w-1]) sb = sb - (longint'(1) <<< w);
                q = 64'(sa / sb) & m;
                r = 64'(sa % sb) & m;
            end else begin
                q = a / b;
                r = a % b;
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input int u, input logic [63:0] a, input logic [63:0] b,
                          input bit sm, input bit st);
        case (u)
            0:       begin a0 = a[31:0]; b0 = b[31:0]; sm0 = sm; st0 = st; end
            1:       begin a1 = a[7:0];  b1 = b[7:0];  sm1 = sm; st1 = st; end
            default: begin a2 = a[15:0]; b2 = b[15:0]; sm2 = sm; st2 = st; end
        endcase
    endtask

    task automatic get_st(input int u, output logic [63:0] q, output logic [63:0] r,
                          output bit z, output bit bsy, output bit dn);
        case (u)
            0:       begin q = 64'(q0); r = 64'(r0); z = z0; bsy = busy0; dn = done0; end
            1:       begin q = 64'(q1); r = 64'(r1); z = z1; bsy = busy1; dn = done1; end
            default: begin q = 64'(q2); r = 64'(r2); z = z2; bsy = busy2; dn = done2; end
        endcase
    endtask

    // One divide: start for a single cycle, scramble operands after accept,
    // count edges to done, watch busy and output hold, and that done is one cycle.
    task automatic run_div(input int u, input logic [63:0] a, input logic [63:0] b, input bit sm,
                           output logic [63:0] q, output logic [63:0] r, output bit z,
                           output int lat, output bit bsy_ok, output bit hold_ok,
                           output bit pulse_ok);
        logic [63:0] qp, rp, qq, rr;
        bit zp, zz, bb, dd;
        @(negedge clk);
        get_st(u, qp, rp, zp, bb, dd);
        set_in(u, a, b, sm, 1'b1);
        @(posedge clk); #1;
        set_in(u, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b0);
        lat = 0; bsy_ok = 1'b1; hold_ok = 1'b1;
        get_st(u, qq, rr, zz, bb, dd);
        while (!dd && lat < 100) begin
            if (!bb) bsy_ok = 1'b0;
            if (qq !== qp || rr !== rp || zz !== zp) hold_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
            get_st(u, qq, rr, zz, bb, dd);
        end
        if (bb) bsy_ok = 1'b0;
        q = qq; r = rr; z = zz;
        @(posedge clk); #1;
        get_st(u, qq, rr, zz, bb, dd);
        pulse_ok = !dd;
    endtask

    initial begin
        vec_t        vt[12];
        logic [63:0] q, r, eq, er, ra, rb, hq, hr;
        bit          z, ez, bok, hok, pok, hz, rsm, hsm;
        int          lat, elat, bad, exp_done, free_at, hl;
        logic [7:0]  ha, hb;

        vt[0]  = '{0, 64'd100,        64'd7,  1'b0, 64'd14,       64'd2,        1'b0, 34};
        vt[1]  = '{1, 64'hF9,         64'h02, 1'b1, 64'hFD,       64'hFF,       1'b0, 10};
        vt[2]  = '{1, 64'h07,         64'hFE, 1'b1, 64'hFD,       64'h01,       1'b0, 10};
        vt[3]  = '{1, 64'h80,         64'hFF, 1'b1, 64'h80,       64'h00,       1'b0, 10};
        vt[4]  = '{1, 64'h5A,         64'h00, 1'b1, 64'hFF,       64'h5A,       1'b1, 1};
        vt[5]  = '{1, 64'd100,        64'd7,  1'b0, 64'd14,       64'd2,        1'b0, 10};
        vt[6]  = '{2, 64'hFFFF,       64'h02, 1'b1, 64'h7FFF,     64'h0001,     1'b0, 17};
        vt[7]  = '{2, 64'h1234,       64'h00, 1'b0, 64'hFFFF,     64'h1234,     1'b1, 1};
        vt[8]  = '{1, 64'hFE,         64'hFF, 1'b0, 64'h00,       64'hFE,       1'b0, 10};
        vt[9]  = '{1, 64'hFF,         64'h80, 1'b0, 64'h01,       64'h7F,       1'b0, 10};
        vt[10] = '{1, 64'h80,         64'h7F, 1'b1, 64'hFF,       64'hFF,       1'b0, 10};
        vt[11] = '{0, 64'hFFFFFFF9,   64'h02, 1'b1, 64'hFFFFFFFD, 64'hFFFFFFFF, 1'b0, 34};

        rst = 1'b0;
        for (int u = 0; u < 3; u++) set_in(u, 64'd0, 64'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            get_st(u, q, r, z, bok, pok);
            chk($sformatf("reset_q_u%0d", u), q, 64'd0);
            chk($sformatf("reset_r_u%0d", u), r, 64'd0);
            chk($sformatf("reset_z_u%0d", u), 64'(z), 64'd0);
            chk($sformatf("reset_busy_u%0d", u), 64'(bok), 64'd0);
            chk($sformatf("reset_done_u%0d", u), 64'(pok), 64'd0);
        end
        @(negedge clk);
        rst = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            run_div(vt[i].u, vt[i].a, vt[i].b, vt[i].sm, q, r, z, lat, bok, hok, pok);
            chk($sformatf("vec%0d_quotient", i), q, vt[i].q);
            chk($sformatf("vec%0d_remainder", i), r, vt[i].r);
            chk($sformatf("vec%0d_div_by_zero", i), 64'(z), 64'(vt[i].z));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].lat));
            chk($sformatf("vec%0d_busy", i), 64'(bok), 64'd1);
            chk($sformatf("vec%0d_hold", i), 64'(hok), 64'd1);
            chk($sformatf("vec%0d_done_pulse", i), 64'(pok), 64'd1);
        end

        // Reset in the middle of CALC abandons the divide.
        @(negedge clk);
        set_in(0, 64'd1000, 64'd3, 1'b0, 1'b1);
        @(posedge clk); #1;
        set_in(0, 64'd0, 64'd0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midreset_q", 64'(q0), 64'd0);
        chk("midreset_r", 64'(r0), 64'd0);
        chk("midreset_busy", 64'(busy0), 64'd0);
        chk("midreset_done", 64'(done0), 64'd0);
        chk("midreset_z", 64'(z0), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done0 || busy0) bad++;
        end
        chk("midreset_no_done", 64'(bad), 64'd0);

        // Handshake: start held high, operands changing every cycle.
        exp_done = -1; free_at = 0;
        hq = '0; hr = '0; hz = 1'b0;
        for (int e = 0; e < 90; e++) begin
            @(negedge clk);
            ha  = 8'($urandom);
            hb  = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
            hsm = 1'($urandom);
            set_in(1, 64'(ha), 64'(hb), hsm, 1'b1);
            @(posedge clk); #1;
            if (e >= free_at) begin
                model(8, 1'b1, 64'(ha), 64'(hb), hsm, hq, hr, hz, hl);
                exp_done = e + hl;
                free_at  = e + hl + 1;
            end
            chk($sformatf("hs_done_e%0d", e), 64'(done1), 64'(e == exp_done));
            if (e == exp_done) begin
                chk($sformatf("hs_quotient_e%0d", e), 64'(q1), hq);
                chk($sformatf("hs_remainder_e%0d", e), 64'(r1), hr);
                chk($sformatf("hs_div_by_zero_e%0d", e), 64'(z1), 64'(hz));
            end
        end
        @(negedge clk);
        set_in(1, 64'd0, 64'd0, 1'b0, 1'b0);
        repeat (14) @(posedge clk);

        // Randomized divides against the reference model.
        for (int u = 0; u < 3; u++) begin
            for (int i = 0; i < 25; i++) begin
                ra  = {$urandom, $urandom};
                rb  = ($urandom_range(0, 7) == 0) ? 64'd0 :
                      (64'($urandom) >> $urandom_range(0, wof(u) - 1));
                if ((rb & ((64'd1 << wof(u)) - 64'd1)) == 0 && $urandom_range(0, 1) == 1) rb = 64'd1;
                rsm = 1'($urandom);
                model(wof(u), sen_of(u), ra, rb, rsm, eq, er, ez, elat);
                run_div(u, ra, rb, rsm, q, r, z, lat, bok, hok, pok);
                chk($sformatf("rnd_u%0d_%0d_quotient", u, i), q, eq);
                chk($sformatf("rnd_u%0d_%0d_remainder", u, i), r, er);
                chk($sformatf("rnd_u%0d_%0d_div_by_zero", u, i), 64'(z), 64'(ez));
                chk($sformatf("rnd_u%0d_%0d_latency", u, i), 64'(lat), 64'(elat));
                chk($sformatf("rnd_u%0d_%0d_busy", u, i), 64'(bok), 64'd1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
